// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer: default step
// positions, counter width, frame mode encoding and $4017 data bit positions.
package apu_pkg;

  localparam int CNT_W_DEF = 15;

  localparam int STEP1_DEF = 3728;
  localparam int STEP2_DEF = 7456;
  localparam int STEP3_DEF = 11185;
  localparam int STEP4_DEF = 14914;
  localparam int STEP5_DEF = 18640;

  typedef enum logic {
    FRAME_4STEP = 1'b0,
    FRAME_5STEP = 1'b1
  } frame_mode_t;

  // Positions inside the 2-bit wdata bus ({mode, irq_inhibit} = $4017[7:6])
  localparam int WDATA_MODE_BIT    = 1;
  localparam int WDATA_INHIBIT_BIT = 0;

endpackage

// File: rtl/apu_frame_step_decode.sv
// Combinational step decoder: turns the current step count and frame mode
// into quarter/half/IRQ hits and the end-of-frame marker.
module apu_frame_step_decode
  import apu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF,
  parameter int STEP4 = STEP4_DEF,
  parameter int STEP5 = STEP5_DEF
) (
  input  logic [CNT_W-1:0] cnt,
  input  frame_mode_t      mode,
  output logic             q_hit,
  output logic             h_hit,
  output logic             irq_hit,
  output logic             last
);

  logic atStep1;
  logic atStep2;
  logic atStep3;
  logic atStep4;
  logic atStep5;
  logic fourStep;

  assign atStep1  = (cnt == CNT_W'(STEP1));
  assign atStep2  = (cnt == CNT_W'(STEP2));
  assign atStep3  = (cnt == CNT_W'(STEP3));
  assign atStep4  = (cnt == CNT_W'(STEP4));
  assign atStep5  = (cnt == CNT_W'(STEP5));
  assign fourStep = (mode == FRAME_4STEP);

  // STEP4 is the frame end in 4-step mode; in 5-step mode it is silent and STEP5 ends the frame
  assign last    = fourStep ? atStep4 : atStep5;
  assign q_hit   = atStep1 | atStep2 | atStep3 | last;
  assign h_hit   = atStep2 | last;
  assign irq_hit = fourStep & atStep4;

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame counter: paces quarter/half-frame clocks for all channels from the
// apuclk strobe, raises the frame IRQ and handles $4017 mode/restart writes.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int STEP1 = STEP1_DEF,
  parameter int STEP2 = STEP2_DEF,
  parameter int STEP3 = STEP3_DEF,
  parameter int STEP4 = STEP4_DEF,
  parameter int STEP5 = STEP5_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       apuclk,
  input  logic       wr_4017,
  input  logic [1:0] wdata,
  input  logic       rd_4015,
  output logic       qframe,
  output logic       hframe,
  output logic       irq,
  output logic       mode
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pending_q;
  logic             pending_d;
  frame_mode_t      mode_q;
  frame_mode_t      mode_d;
  logic             inhibit_q;
  logic             inhibit_d;
  logic             qframe_q;
  logic             qframe_d;
  logic             hframe_q;
  logic             hframe_d;
  logic             irq_q;
  logic             irq_d;

  logic qHit;
  logic hHit;
  logic irqHit;
  logic lastStep;

  apu_frame_step_decode #(
    .CNT_W (CNT_W),
    .STEP1 (STEP1),
    .STEP2 (STEP2),
    .STEP3 (STEP3),
    .STEP4 (STEP4),
    .STEP5 (STEP5)
  ) u_decode (
    .cnt     (cnt_q),
    .mode    (mode_q),
    .q_hit   (qHit),
    .h_hit   (hHit),
    .irq_hit (irqHit),
    .last    (lastStep)
  );

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    qframe_d  = 1'b0;
    hframe_d  = 1'b0;
    irq_d     = irq_q;

    // A restart tick consumes the pending write instead of comparing the count
    if (apuclk) begin
      if (pending_q) begin
        cnt_d     = '0;
        pending_d = 1'b0;
        qframe_d  = (mode_q == FRAME_5STEP);
        hframe_d  = (mode_q == FRAME_5STEP);
      end else begin
        cnt_d    = lastStep ? '0 : cnt_q + 1'b1;
        qframe_d = qHit;
        hframe_d = hHit;
      end
    end

    if (wr_4017) begin
      mode_d    = frame_mode_t'(wdata[WDATA_MODE_BIT]);
      inhibit_d = wdata[WDATA_INHIBIT_BIT];
      pending_d = 1'b1;
    end

    // The set is applied after the clear so a coincident $4015 read loses
    if (rd_4015 || inhibit_d) begin
      irq_d = 1'b0;
    end
    if (apuclk && !pending_q && irqHit && !inhibit_d) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      mode_q    <= FRAME_4STEP;
      inhibit_q <= 1'b0;
      qframe_q  <= 1'b0;
      hframe_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      qframe_q  <= qframe_d;
      hframe_q  <= hframe_d;
      irq_q     <= irq_d;
    end
  end

  assign qframe = qframe_q;
  assign hframe = hframe_q;
  assign irq    = irq_q;
  assign mode   = logic'(mode_q);

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer: expected pulses are queued with
// their hand-computed apuclk tick number and popped by a monitor on each pulse.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       apuclk;
  logic       wr_4017;
  logic [1:0] wdata;
  logic       rd_4015;
  logic       qframe;
  logic       hframe;
  logic       irq;
  logic       mode;

  int checks   = 0;
  int failures = 0;
  int tickNum  = 0;
  bit prevStrobe = 1'b0;

  typedef struct packed {
    int   tick;
    logic q;
    logic h;
  } pulse_t;

  pulse_t expQ[$];

  always #5 clk = ~clk;

  apu_frame_sequencer dut (
    .clk     (clk),
    .n_reset (n_reset),
    .apuclk  (apuclk),
    .wr_4017 (wr_4017),
    .wdata   (wdata),
    .rd_4015 (rd_4015),
    .qframe  (qframe),
    .hframe  (hframe),
    .irq     (irq),
    .mode    (mode)
  );

  // Ticks are numbered from 1 across the whole run, counting accepted strobes
  always @(posedge clk) begin
    prevStrobe = (apuclk === 1'b1) && (n_reset === 1'b1);
    if (prevStrobe) tickNum++;
  end

  always @(negedge clk) begin
    pulse_t e;
    if (qframe === 1'b1 || hframe === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpectedPulse: got tick=%0d q=%b h=%b, expected no pulse",
                 tickNum, qframe, hframe);
      end else begin
        e = expQ.pop_front();
        if (e.tick != tickNum || e.q !== qframe || e.h !== hframe || !prevStrobe) begin
          failures++;
          $display("[TB] FAIL pulse: got tick=%0d q=%b h=%b strobe=%b, expected tick=%0d q=%b h=%b strobe=1",
                   tickNum, qframe, hframe, prevStrobe, e.tick, e.q, e.h);
        end
      end
    end
  end

  initial begin
    repeat (120000) @(posedge clk);
    failures++;
    $display("[TB] FAIL watchdog: got run still active after 120000 clks, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushPulse(input int t, input logic q, input logic h);
    expQ.push_back('{tick: t, q: q, h: h});
  endtask

  task automatic expectFrame4(input int s);
    pushPulse(s + 3728,  1'b1, 1'b0);
    pushPulse(s + 7456,  1'b1, 1'b1);
    pushPulse(s + 11185, 1'b1, 1'b0);
    pushPulse(s + 14914, 1'b1, 1'b1);
  endtask

  task automatic expectFrame5(input int s);
    pushPulse(s + 3728,  1'b1, 1'b0);
    pushPulse(s + 7456,  1'b1, 1'b1);
    pushPulse(s + 11185, 1'b1, 1'b0);
    pushPulse(s + 18640, 1'b1, 1'b1);
  endtask

  // Issues n apuclk strobes, one every gap clocks; called and returns at a negedge
  task automatic applyStimulus(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      apuclk = 1'b1;
      @(negedge clk);
      apuclk = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    int s;
    int r;
    n_reset = 1'b0;
    apuclk  = 1'b0;
    wr_4017 = 1'b0;
    wdata   = 2'b00;
    rd_4015 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetQframe", qframe, 0);
    checkOutput("resetHframe", hframe, 0);
    checkOutput("resetIrq", irq, 0);
    checkOutput("resetMode", mode, 0);
    n_reset = 1'b1;

    // 4-step frame, first stretch with apuclk every 2nd clk
    s = tickNum + 1;
    expectFrame4(s);
    applyStimulus(3800, 2);
    applyStimulus(14914 - 3800, 1);
    checkOutput("irqBeforeStep4", irq, 0);
    rd_4015 = 1'b1;
    applyStimulus(1, 1);
    rd_4015 = 1'b0;
    checkOutput("irqSetBeatsRead", irq, 1);

    // Inhibit write at cnt 5000 landing on an apuclk, then two inhibited frames
    s = s + 14915;
    pushPulse(s + 3728, 1'b1, 1'b0);
    applyStimulus(5000, 1);
    checkOutput("irqHeldUntilWrite", irq, 1);
    wr_4017 = 1'b1;
    wdata   = 2'b01;
    applyStimulus(1, 1);
    wr_4017 = 1'b0;
    checkOutput("irqClearedByInhibit", irq, 0);
    checkOutput("modeAfterInhibitWrite", mode, 0);
    r = tickNum + 1;
    s = r + 1;
    expectFrame4(s);
    expectFrame4(s + 14915);
    applyStimulus(1 + 14915, 1);
    checkOutput("irqInhibitFrame1", irq, 0);
    applyStimulus(14915, 1);
    checkOutput("irqInhibitFrame2", irq, 0);

    // Run to cnt 7000, leave a write pending, then pulse reset for one clk
    s = s + 29830;
    pushPulse(s + 3728, 1'b1, 1'b0);
    applyStimulus(7000, 1);
    wr_4017 = 1'b1;
    wdata   = 2'b10;
    @(negedge clk);
    wr_4017 = 1'b0;
    checkOutput("modeLatchImmediate", mode, 1);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    checkOutput("midResetQframe", qframe, 0);
    checkOutput("midResetHframe", hframe, 0);
    checkOutput("midResetIrq", irq, 0);
    checkOutput("midResetMode", mode, 0);

    s = tickNum + 1;
    expectFrame4(s);
    applyStimulus(14915, 1);
    checkOutput("irqSetAfterReset", irq, 1);
    rd_4015 = 1'b1;
    @(negedge clk);
    rd_4015 = 1'b0;
    checkOutput("irqClearedByRead", irq, 0);

    // Back-to-back writes, last (5-step) wins with a single restart
    wr_4017 = 1'b1;
    wdata   = 2'b01;
    @(negedge clk);
    wdata   = 2'b10;
    @(negedge clk);
    wr_4017 = 1'b0;
    checkOutput("modeFiveStep", mode, 1);
    r = tickNum + 1;
    pushPulse(r, 1'b1, 1'b1);
    s = r + 1;
    expectFrame5(s);
    applyStimulus(1 + 18641, 1);
    checkOutput("irqQuietFiveStep", irq, 0);
    checkOutput("modeStillFiveStep", mode, 1);

    repeat (4) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
